// File: rtl/interval_timer_if.sv
// Purpose : groups the light-FSM / divider / reprogram signals of the
//           interval timer into one bundle.
// Signals : one_hz_enable  - one-cycle tick per second
//           start_timer    - one-cycle request to begin timing an interval
//           interval       - interval selector sampled with start_timer
//           prog_sync      - synchronized reprogram strobe
//           time_selector  - table entry to overwrite on prog_sync
//           time_value     - new interval value in seconds
//           expired        - one-cycle pulse when the running interval ends
//           busy           - high while an interval is counting
//           remaining      - seconds left; 0 when not counting
// Modports: master drives the requests and observes status; slave is the timer.
interface interval_timer_if;
  logic       one_hz_enable;
  logic       start_timer;
  logic [1:0] interval;
  logic       prog_sync;
  logic [1:0] time_selector;
  logic [3:0] time_value;
  logic       expired;
  logic       busy;
  logic [3:0] remaining;

  modport master (
    output one_hz_enable, start_timer, interval, prog_sync, time_selector, time_value,
    input  expired, busy, remaining
  );

  modport slave (
    input  one_hz_enable, start_timer, interval, prog_sync, time_selector, time_value,
    output expired, busy, remaining
  );
endinterface

// File: rtl/interval_timer.sv
// Purpose : programmable seconds timer for a traffic-light controller. A
//           4-entry table holds the green/extended/yellow/walk intervals;
//           start_timer snapshots the selected entry into a down-counter that
//           steps on each one_hz_enable tick and pulses expired at the end.
// Ports   : clk   - system clock, rising edge
//           reset - synchronous, active-low
//           tif   - interval_timer_if.slave (requests, reprogram, status)
module interval_timer #(
  parameter logic [3:0] T_BASE = 4'd6,
  parameter logic [3:0] T_EXT  = 4'd3,
  parameter logic [3:0] T_YEL  = 4'd2,
  parameter logic [3:0] T_WALK = 4'd3
) (
  input  logic             clk,
  input  logic             reset,
  interval_timer_if.slave  tif
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned N_ENTRY = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    EXPIRE = 2'b10
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic [CNT_W-1:0]   tbl [N_ENTRY];
  logic [CNT_W-1:0]   load_val;
  logic [CNT_W-1:0]   wr_val;
  logic               expired_q;
  logic               busy_q;
  logic [CNT_W-1:0]   remaining_q;

  // Table read uses the registered contents, so a same-cycle write to the
  // selected entry only affects later starts.
  assign load_val = tbl[tif.interval];

  // A zero interval would never expire; store it as one second.
  assign wr_val = (tif.time_value == '0) ? CNT_W'(1) : tif.time_value;

  // Next-state and counter logic. A start always wins over a coincident tick,
  // which also makes the load cycle ignore one_hz_enable.
  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      IDLE: begin
        if (tif.start_timer) begin
          state_next = RUN;
          count_next = load_val;
        end
      end
      RUN: begin
        if (tif.start_timer) begin
          count_next = load_val;
        end else if (tif.one_hz_enable) begin
          if (count <= CNT_W'(1)) begin
            state_next = EXPIRE;
            count_next = '0;
          end else begin
            count_next = count - CNT_W'(1);
          end
        end
      end
      EXPIRE: begin
        if (tif.start_timer) begin
          state_next = RUN;
          count_next = load_val;
        end else begin
          state_next = IDLE;
          count_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  // State, counter and table registers; outputs are registered from the
  // next state so they line up exactly with the state they describe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      count       <= '0;
      expired_q   <= 1'b0;
      busy_q      <= 1'b0;
      remaining_q <= '0;
      tbl[0]      <= T_BASE;
      tbl[1]      <= T_EXT;
      tbl[2]      <= T_YEL;
      tbl[3]      <= T_WALK;
    end else begin
      state       <= state_next;
      count       <= count_next;
      expired_q   <= (state_next == EXPIRE);
      busy_q      <= (state_next == RUN);
      remaining_q <= (state_next == RUN) ? count_next : '0;
      if (tif.prog_sync) begin
        tbl[tif.time_selector] <= wr_val;
      end
    end
  end

  assign tif.expired   = expired_q;
  assign tif.busy      = busy_q;
  assign tif.remaining = remaining_q;

endmodule
